reg_wr_port_ctrl: RTL and testbench

// - Sequences and shares the single register-file write port between two writeback requesters: ALU and memory load.
// - Captures the winner's register number and data, then drives the 4-bit write opcode into the register write-select decoder.
// - Holds the opcode stable for SETUP_CYCLES so the gate-level decoder settles, then issues a one-cycle active-low write strobe.
// - Register 13 has no decoder output: it is reserved and never written.

---
 rtl/reg_wr_pkg.sv | 8 +
 rtl/reg_wr_arb2.sv | 19 +
 rtl/reg_wr_port_ctrl.sv | 93 +++++++++
 tb/tb_reg_wr_port_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/reg_wr_pkg.sv
// reg_wr_pkg: shared types and constants for the register-file write-port controller
package reg_wr_pkg;
  localparam int REG_W = 4;
  localparam int DATA_W = 16;
  localparam logic [REG_W-1:0] RESERVED_REG = 4'd13;
  typedef enum logic [1:0] {IDLE, SETUP, WRITE} state_t;
  typedef enum logic {REQ_ALU = 1'b0, REQ_MEM = 1'b1} req_id_t;
endpackage

// File: rtl/reg_wr_arb2.sv
// reg_wr_arb2: 2-way one-hot arbiter, bit 0 = ALU, bit 1 = MEM
// REG_WR_RR_EN selects round-robin on rr_ptr; otherwise ALU has fixed priority.
module reg_wr_arb2
  import reg_wr_pkg::*;
(
`ifdef REG_WR_RR_EN
  input  req_id_t    rr_ptr,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  always_comb begin
`ifdef REG_WR_RR_EN
    gnt = (req[1] && (rr_ptr == REQ_MEM || !req[0])) ? 2'b10 : {1'b0, req[0]};
`else
    gnt = req[0] ? 2'b01 : {req[1], 1'b0};
`endif
  end
endmodule

// File: rtl/reg_wr_port_ctrl.sv
// reg_wr_port_ctrl: shares the register-file write port between ALU and load writeback
// Arbitration is round-robin when REG_WR_RR_EN is defined, else fixed ALU-first.
module reg_wr_port_ctrl
  import reg_wr_pkg::*;
#(
  parameter int NAND_TIME    = 7,
  parameter int SETUP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_req,
  input  logic [REG_W-1:0]  alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ack,
  input  logic              mem_req,
  input  logic [REG_W-1:0]  mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ack,
  output logic [REG_W-1:0]  wr_op,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en_n,
  output logic              busy,
  output logic              bad_reg
);
  localparam logic [2:0] SC = 3'(SETUP_CYCLES);
  // NAND_TIME only matters to timing-annotated netlists; the RTL is zero-delay
  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 7 || NAND_TIME < 0) begin : g_bad_param
    $error("reg_wr_port_ctrl: SETUP_CYCLES must be 1..7 and NAND_TIME non-negative");
  end
  state_t            state, state_nxt;
  logic [2:0]        cnt;
  logic [1:0]        gnt;
  req_id_t           win, win_q;
  logic              drop_q, hit_res, grant;
  logic [REG_W-1:0]  win_reg;
  logic [DATA_W-1:0] win_data;
`ifdef REG_WR_RR_EN
  req_id_t rr_ptr;
`endif
  reg_wr_arb2 u_arb (
`ifdef REG_WR_RR_EN
    .rr_ptr(rr_ptr),
`endif
    .req   ({mem_req, alu_req}),
    .gnt   (gnt)
  );
  always_comb begin
    win      = gnt[1] ? REQ_MEM : REQ_ALU;
    win_reg  = gnt[1] ? mem_reg : alu_reg;
    win_data = gnt[1] ? mem_data : alu_data;
    hit_res  = win_reg == RESERVED_REG;
    grant    = state == IDLE && |gnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // A reserved-register hit borrows WRITE for its ack cycle but suppresses the strobe
  always_comb begin
    state_nxt = state == IDLE  ? (|gnt ? (hit_res ? WRITE : SETUP) : IDLE) :
                state == SETUP ? (cnt == SC ? WRITE : SETUP) : IDLE;
  end
  always_comb begin
    wr_en_n = !(state == WRITE && !drop_q);
    alu_ack = state == WRITE && win_q == REQ_ALU;
    mem_ack = state == WRITE && win_q == REQ_MEM;
    bad_reg = state == WRITE && drop_q;
    busy    = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      win_q   <= REQ_ALU;
      drop_q  <= 1'b0;
      wr_op   <= '0;
      wr_data <= '0;
    end else if (grant) begin
      cnt    <= 3'd1;
      win_q  <= win;
      drop_q <= hit_res;
      if (!hit_res) begin
        wr_op   <= win_reg;
        wr_data <= win_data;
      end
    end else if (state == SETUP && cnt != SC) begin
      cnt <= cnt + 3'd1;
    end
  end
`ifdef REG_WR_RR_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr <= REQ_ALU;
    else if (grant) rr_ptr <= win == REQ_ALU ? REQ_MEM : REQ_ALU;
`endif
endmodule

// File: tb/tb_reg_wr_port_ctrl.sv
// tb_reg_wr_port_ctrl: directed self-checking bench, SETUP_CYCLES=2
module tb_reg_wr_port_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        alu_req = 1'b0, mem_req = 1'b0;
  logic [3:0]  alu_reg = '0, mem_reg = '0;
  logic [15:0] alu_data = '0, mem_data = '0;
  logic        alu_ack, mem_ack, wr_en_n, busy, bad_reg;
  logic [3:0]  wr_op;
  logic [15:0] wr_data;
  logic [4:0]  ctl;
  int          checks = 0, errors = 0;
  // ctl = {busy, wr_en_n, alu_ack, mem_ack, bad_reg}
  localparam logic [4:0] C_IDLE = 5'b01000, C_SETUP = 5'b11000,
                         C_ALU  = 5'b10100, C_MEM   = 5'b10010, C_BAD_MEM = 5'b11011;
  assign ctl = {busy, wr_en_n, alu_ack, mem_ack, bad_reg};
  always #5 clk = ~clk;
  reg_wr_port_ctrl #(.NAND_TIME(7), .SETUP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_req(alu_req), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ack(alu_ack),
    .mem_req(mem_req), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ack(mem_ack),
    .wr_op(wr_op), .wr_data(wr_data), .wr_en_n(wr_en_n), .busy(busy), .bad_reg(bad_reg)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_ctl", ctl, C_IDLE);
    check("rst_op", wr_op, 4'h0);
    check("rst_data", wr_data, 16'h0);
    tick(2);
    rst_n = 1'b1;
    // single ALU write
    alu_req = 1'b1; alu_reg = 4'd5; alu_data = 16'hBEEF;
    tick();
    check("t1_c1_ctl", ctl, C_SETUP);
    check("t1_c1_op", wr_op, 4'd5);
    tick();
    check("t1_c2_ctl", ctl, C_SETUP);
    tick();
    check("t1_c3_ctl", ctl, C_ALU);
    check("t1_c3_data", wr_data, 16'hBEEF);
    alu_req = 1'b0;
    tick();
    check("t1_c4_ctl", ctl, C_IDLE);
    check("t1_c4_op", wr_op, 4'd5);
    // reserved register on the load port
    mem_req = 1'b1; mem_reg = 4'd13; mem_data = 16'hDEAD;
    tick();
    check("t3_c1_ctl", ctl, C_BAD_MEM);
    check("t3_c1_op", wr_op, 4'd5);
    check("t3_c1_data", wr_data, 16'hBEEF);
    mem_req = 1'b0;
    tick();
    check("t3_c2_ctl", ctl, C_IDLE);
    // simultaneous requests, ALU withdraws after its ack
    alu_req = 1'b1; alu_reg = 4'd3; alu_data = 16'h1111;
    mem_req = 1'b1; mem_reg = 4'd9; mem_data = 16'h2222;
    tick(2);
    check("t2_c2_op", wr_op, 4'd3);
    tick();
    check("t2_c3_ctl", ctl, C_ALU);
    check("t2_c3_data", wr_data, 16'h1111);
    alu_req = 1'b0;
    tick();
    check("t2_c4_ctl", ctl, C_IDLE);
    tick();
    check("t2_c5_op", wr_op, 4'd9);
    tick(2);
    check("t2_c7_ctl", ctl, C_MEM);
    check("t2_c7_data", wr_data, 16'h2222);
    mem_req = 1'b0;
    tick();
    check("t2_c8_ctl", ctl, C_IDLE);
    // both held, ALU re-requests on its ack cycle
    alu_req = 1'b1; alu_reg = 4'd3; alu_data = 16'h1111;
    mem_req = 1'b1; mem_reg = 4'd9; mem_data = 16'h2222;
    tick(3);
    check("t2b_c3_ctl", ctl, C_ALU);
    alu_reg = 4'd4; alu_data = 16'h3333;
    tick();
    check("t2b_c4_ctl", ctl, C_IDLE);
    tick(3);
`ifdef REG_WR_RR_EN
    check("t2b_c7_ctl", ctl, C_MEM);
    check("t2b_c7_op", wr_op, 4'd9);
`else
    check("t2b_c7_ctl", ctl, C_ALU);
    check("t2b_c7_op", wr_op, 4'd4);
`endif
    alu_req = 1'b0; mem_req = 1'b0;
    tick();
    check("t2b_c8_ctl", ctl, C_IDLE);
    // back-to-back ALU with a new destination
    alu_req = 1'b1; alu_reg = 4'd2; alu_data = 16'h0A0A;
    tick(3);
    check("t5_c3_ctl", ctl, C_ALU);
    check("t5_c3_data", wr_data, 16'h0A0A);
    alu_reg = 4'd7; alu_data = 16'h7777;
    tick();
    check("t5_c4_ctl", ctl, C_IDLE);
    tick();
    check("t5_c5_ctl", ctl, C_SETUP);
    check("t5_c5_op", wr_op, 4'd7);
    tick();
    check("t5_c6_ctl", ctl, C_SETUP);
    tick();
    check("t5_c7_ctl", ctl, C_ALU);
    check("t5_c7_data", wr_data, 16'h7777);
    alu_req = 1'b0;
    tick();
    check("t5_c8_ctl", ctl, C_IDLE);
    // reset during SETUP
    alu_req = 1'b1; alu_reg = 4'd6; alu_data = 16'h6666;
    tick();
    check("t4_c1_ctl", ctl, C_SETUP);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_ctl", ctl, C_IDLE);
    check("t4_rst_op", wr_op, 4'h0);
    check("t4_rst_data", wr_data, 16'h0);
    tick();
    check("t4_hold_ctl", ctl, C_IDLE);
    rst_n = 1'b1;
    tick();
    check("t4_r1_ctl", ctl, C_SETUP);
    check("t4_r1_op", wr_op, 4'd6);
    tick();
    check("t4_r2_ctl", ctl, C_SETUP);
    tick();
    check("t4_r3_ctl", ctl, C_ALU);
    check("t4_r3_data", wr_data, 16'h6666);
    alu_req = 1'b0;
    tick();
    check("t4_r4_ctl", ctl, C_IDLE);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
